i2s_tx_sample_unpack: RTL and testbench

//  Upstream feeder of the I2S TX DSP channel, in the sck_i domain between the uDMA TX CDC FIFO and the channel's fifo_data_i port.

---
 rtl/i2s_pkg.sv | 31 +++
 rtl/i2s_tx_slot_mux.sv | 41 ++++
 rtl/i2s_tx_sample_unpack.sv | 95 +++++++++
 tb/tb_i2s_tx_sample_unpack.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types and helpers for the I2S TX sample unpacker.
// Slot geometry per packing mode lives here so the FSM and slot mux agree.
package i2s_pkg;

   localparam int I2S_DATA_W = 32;

   typedef enum logic [1:0] {
      PACK_1X32 = 2'b00,
      PACK_2X16 = 2'b01,
      PACK_4X8  = 2'b10,
      PACK_RSVD = 2'b11
   } pack_mode_e;

   // The reserved encoding behaves as one full-width slot.
   function automatic logic [2:0] n_slots(input pack_mode_e mode);
      case (mode)
         PACK_2X16: return 3'd2;
         PACK_4X8:  return 3'd4;
         default:   return 3'd1;
      endcase
   endfunction

   function automatic logic [5:0] slot_width(input pack_mode_e mode);
      case (mode)
         PACK_2X16: return 6'd16;
         PACK_4X8:  return 6'd8;
         default:   return 6'd32;
      endcase
   endfunction

endpackage

// File: rtl/i2s_tx_slot_mux.sv
// Combinational slot select plus width mask for one unpacked audio sample.
// With I2S_TX_UNPACK_SIGN_EXT_EN defined, bits above num_bits sign-extend instead of zero-fill.
module i2s_tx_slot_mux
   import i2s_pkg::*;
(
   input  logic [I2S_DATA_W-1:0] word_i,
   input  pack_mode_e            pack_i,
   input  logic                  order_i,
   input  logic [1:0]            slot_i,
   input  logic [4:0]            num_bits_i,
   output logic [I2S_DATA_W-1:0] sample_o
);

   logic [2:0]            nslots;
   logic [1:0]            phys;
   logic [5:0]            shift;
   logic [I2S_DATA_W-1:0] slot_mask;
   logic [I2S_DATA_W-1:0] raw;
   logic [I2S_DATA_W-1:0] nb_mask;

   always_comb begin
      nslots = n_slots(pack_i);
      // Logical slot index counts emission order; physical index picks the bit field.
      phys   = order_i ? 2'(nslots - 3'd1 - {1'b0, slot_i}) : slot_i;
      shift  = 6'(phys) * slot_width(pack_i);
      case (pack_i)
         PACK_2X16: slot_mask = 32'h0000_FFFF;
         PACK_4X8:  slot_mask = 32'h0000_00FF;
         default:   slot_mask = 32'hFFFF_FFFF;
      endcase
      raw     = (word_i >> shift) & slot_mask;
      nb_mask = 32'hFFFF_FFFF >> (5'd31 - num_bits_i);
`ifdef I2S_TX_UNPACK_SIGN_EXT_EN
      // raw is zero above the slot, so a sample wider than its slot still extends with 0.
      sample_o = (raw & nb_mask) | (~nb_mask & {I2S_DATA_W{raw[num_bits_i]}});
`else
      sample_o = raw & nb_mask;
`endif
   end

endmodule

// File: rtl/i2s_tx_sample_unpack.sv
// Splits 32-bit uDMA words into 1/2/4 samples, one per valid/ready beat, and flags underrun.
// Optional macro I2S_TX_UNPACK_SIGN_EXT_EN selects sign extension in the slot mux.
module i2s_tx_sample_unpack
   import i2s_pkg::*;
#(
   parameter int DATA_W = I2S_DATA_W
) (
   input  logic              sck_i,
   input  logic              rstn_i,
   input  logic              cfg_en_i,
   input  logic [1:0]        cfg_pack_i,
   input  logic              cfg_msb_slot_first_i,
   input  logic [4:0]        cfg_num_bits_i,
   input  logic [DATA_W-1:0] in_data_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   output logic [DATA_W-1:0] out_data_o,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic              underrun_o
);

   typedef enum logic {ST_IDLE, ST_HOLD} state_e;

   state_e            state_q;
   logic [DATA_W-1:0] word_q;
   pack_mode_e        pack_q;
   logic              order_q;
   logic [1:0]        slot_q;
   logic              primed_q;
   logic              out_valid_q;

   logic              last_slot;
   logic              out_hs;
   logic              in_hs;
   logic [DATA_W-1:0] sample;

   assign last_slot = ({1'b0, slot_q} == (n_slots(pack_q) - 3'd1));
   assign out_hs    = out_valid_q & out_ready_i;

   // Ready is combinational so the next word loads on the same beat the last slot leaves.
   assign in_ready_o = cfg_en_i &
                       ((state_q == ST_IDLE) | ((state_q == ST_HOLD) & last_slot & out_ready_i));
   assign in_hs      = in_valid_i & in_ready_o;

   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_valid_q ? sample : '0;
   assign underrun_o  = out_ready_i & ~out_valid_q & primed_q & cfg_en_i;

   i2s_tx_slot_mux u_slot_mux (
      .word_i     (word_q),
      .pack_i     (pack_q),
      .order_i    (order_q),
      .slot_i     (slot_q),
      .num_bits_i (cfg_num_bits_i),
      .sample_o   (sample)
   );

   always_ff @(posedge sck_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q     <= ST_IDLE;
         word_q      <= '0;
         pack_q      <= PACK_1X32;
         order_q     <= 1'b0;
         slot_q      <= 2'd0;
         primed_q    <= 1'b0;
         out_valid_q <= 1'b0;
      end else if (!cfg_en_i) begin
         // Flush: any partially emitted word is dropped, underrun detection re-arms.
         state_q     <= ST_IDLE;
         slot_q      <= 2'd0;
         primed_q    <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         if (out_hs) primed_q <= 1'b1;
         if (in_hs) begin
            word_q      <= in_data_i;
            pack_q      <= pack_mode_e'(cfg_pack_i);
            order_q     <= cfg_msb_slot_first_i;
            slot_q      <= 2'd0;
            state_q     <= ST_HOLD;
            out_valid_q <= 1'b1;
         end else if (state_q == ST_HOLD && out_ready_i) begin
            if (last_slot) begin
               state_q     <= ST_IDLE;
               slot_q      <= 2'd0;
               out_valid_q <= 1'b0;
            end else begin
               slot_q <= slot_q + 2'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_i2s_tx_sample_unpack.sv
// Scoreboard bench: stimulus pushes expected samples, a negedge monitor pops on each handshake.
// Expected values follow I2S_TX_UNPACK_SIGN_EXT_EN when defined.
module tb_i2s_tx_sample_unpack;

`ifdef I2S_TX_UNPACK_SIGN_EXT_EN
   localparam bit SX = 1'b1;
`else
   localparam bit SX = 1'b0;
`endif

   logic        sck_i = 1'b0;
   logic        rstn_i;
   logic        cfg_en_i;
   logic [1:0]  cfg_pack_i;
   logic        cfg_msb_slot_first_i;
   logic [4:0]  cfg_num_bits_i;
   logic [31:0] in_data_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [31:0] out_data_o;
   logic        out_valid_o;
   logic        out_ready_i;
   logic        underrun_o;

   logic [31:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   i2s_tx_sample_unpack dut (
      .sck_i                (sck_i),
      .rstn_i               (rstn_i),
      .cfg_en_i             (cfg_en_i),
      .cfg_pack_i           (cfg_pack_i),
      .cfg_msb_slot_first_i (cfg_msb_slot_first_i),
      .cfg_num_bits_i       (cfg_num_bits_i),
      .in_data_i            (in_data_i),
      .in_valid_i           (in_valid_i),
      .in_ready_o           (in_ready_o),
      .out_data_o           (out_data_o),
      .out_valid_o          (out_valid_o),
      .out_ready_i          (out_ready_i),
      .underrun_o           (underrun_o)
   );

   always #5 sck_i = ~sck_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge sck_i);
      #1;
   endtask

   always @(negedge sck_i) begin
      if (rstn_i && out_valid_o && out_ready_i) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_sample: got %h expected none", out_data_o);
         end else begin
            check("sample", out_data_o, exp_q.pop_front());
         end
      end
   end

   initial begin
      rstn_i = 1'b0; cfg_en_i = 1'b0; cfg_pack_i = 2'b00; cfg_msb_slot_first_i = 1'b0;
      cfg_num_bits_i = 5'd31; in_data_i = '0; in_valid_i = 1'b0; out_ready_i = 1'b0;
      repeat (2) tick();
      check("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
      check("rst_out_data", out_data_o, 32'd0);
      check("rst_in_ready", {31'd0, in_ready_o}, 32'd0);
      check("rst_underrun", {31'd0, underrun_o}, 32'd0);
      rstn_i = 1'b1;
      tick();

      // 1x32 back-to-back words, no bubble
      cfg_en_i = 1'b1; out_ready_i = 1'b1;
      in_data_i = 32'hA5A5_0001; in_valid_i = 1'b1;
      exp_q.push_back(32'hA5A5_0001); exp_q.push_back(32'h0000_0002);
      #1 check("t1_idle_ready", {31'd0, in_ready_o}, 32'd1);
      tick();
      in_data_i = 32'h0000_0002;
      #1 check("t1_b2b_ready", {31'd0, in_ready_o}, 32'd1);
      tick();
      in_valid_i = 1'b0;
      #1 check("t1_no_bubble", {31'd0, out_valid_o}, 32'd1);
      tick();

      // underrun while primed and starved
      #1 check("t4_underrun", {31'd0, underrun_o}, 32'd1);
      check("t4_out_valid", {31'd0, out_valid_o}, 32'd0);
      tick();
      check("t4_underrun_again", {31'd0, underrun_o}, 32'd1);
      out_ready_i = 1'b0;
      #1 check("t4_no_underrun", {31'd0, underrun_o}, 32'd0);

      // 2x16 lsb-slot first
      cfg_pack_i = 2'b01; cfg_num_bits_i = 5'd15; out_ready_i = 1'b1;
      in_data_i = 32'h8001_7FFE; in_valid_i = 1'b1;
      exp_q.push_back(32'h0000_7FFE); exp_q.push_back(SX ? 32'hFFFF_8001 : 32'h0000_8001);
      tick();
      in_valid_i = 1'b0;
      #1 check("t2_mid_ready", {31'd0, in_ready_o}, 32'd0);
      tick(); tick();

      // narrow width on a full slot
      cfg_pack_i = 2'b00; cfg_num_bits_i = 5'd3;
      in_data_i = 32'hFFFF_FFFA; in_valid_i = 1'b1;
      exp_q.push_back(SX ? 32'hFFFF_FFFA : 32'h0000_000A);
      tick();
      in_valid_i = 1'b0;
      tick();

      // num_bits wider than 8-bit slot
      cfg_pack_i = 2'b10; cfg_num_bits_i = 5'd15;
      in_data_i = 32'h8000_00F0; in_valid_i = 1'b1;
      exp_q.push_back(32'h0000_00F0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      exp_q.push_back(32'h0000_0080);
      tick();
      in_valid_i = 1'b0;
      repeat (4) tick();

      // 4x8 msb-slot first, ready toggling
      out_ready_i = 1'b0; cfg_msb_slot_first_i = 1'b1; cfg_num_bits_i = 5'd7;
      in_data_i = 32'h0403_0201; in_valid_i = 1'b1;
      exp_q.push_back(32'h04); exp_q.push_back(32'h03); exp_q.push_back(32'h02);
      exp_q.push_back(32'h01);
      tick();
      in_valid_i = 1'b0;
      begin
         int beats = 0;
         for (int i = 0; i < 7; i++) begin
            out_ready_i = (i % 2 == 0);
            #1 check($sformatf("t3_in_ready_%0d", i), {31'd0, in_ready_o},
                     {31'd0, out_ready_i && beats == 3});
            if (out_ready_i) beats++;
            tick();
         end
      end
      out_ready_i = 1'b0;

      // flush mid-word, restart at slot 0
      cfg_msb_slot_first_i = 1'b0; out_ready_i = 1'b1;
      in_data_i = 32'h1122_3344; in_valid_i = 1'b1;
      exp_q.push_back(32'h44); exp_q.push_back(32'h33);
      tick();
      in_valid_i = 1'b0;
      tick(); tick();
      out_ready_i = 1'b0; cfg_en_i = 1'b0;
      in_data_i = 32'hAABB_CCDD; in_valid_i = 1'b1;
      #1 check("t5_dis_in_ready", {31'd0, in_ready_o}, 32'd0);
      tick();
      out_ready_i = 1'b1;
      #1 check("t5_flush_valid", {31'd0, out_valid_o}, 32'd0);
      check("t5_dis_underrun", {31'd0, underrun_o}, 32'd0);
      tick();
      cfg_en_i = 1'b1;
      exp_q.push_back(32'hDD); exp_q.push_back(32'hCC); exp_q.push_back(32'hBB);
      exp_q.push_back(32'hAA);
      #1 check("t5_unprimed", {31'd0, underrun_o}, 32'd0);
      tick();
      in_valid_i = 1'b0;
      repeat (4) tick();
      out_ready_i = 1'b0;
      tick();

      // pack change mid-word applies to the next word only
      cfg_pack_i = 2'b01; cfg_num_bits_i = 5'd31; out_ready_i = 1'b1;
      in_data_i = 32'h0001_0002; in_valid_i = 1'b1;
      exp_q.push_back(32'h0000_0002); exp_q.push_back(32'h0000_0001);
      tick();
      in_valid_i = 1'b0; cfg_pack_i = 2'b10;
      tick();
      in_data_i = 32'h0D0C_0B0A; in_valid_i = 1'b1;
      exp_q.push_back(32'h0A); exp_q.push_back(32'h0B); exp_q.push_back(32'h0C);
      exp_q.push_back(32'h0D);
      #1 check("t6_last_ready", {31'd0, in_ready_o}, 32'd1);
      tick();
      in_valid_i = 1'b0;
      repeat (4) tick();
      out_ready_i = 1'b0;
      repeat (3) tick();

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
